seqdiv: RTL and testbench
=========================

# seqdiv

Sequential restoring shift-subtract divider: unsigned WIDTH-bit dividend over WIDTH-bit divisor, producing quotient and remainder over 2·WIDTH+1 clock cycles with a start/done handshake. It is the inverse-operation companion to the team's sequential shift-add multiplier. It uses the same start/done protocol so both can share one arithmetic-unit controller. Divide-by-zero is flagged and completes early.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  dividend, sampled on accepting edge
- B  input  WIDTH  divisor, sampled on accepting edge
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle completion pulse
- quot  output  WIDTH  quotient, registered, held until next completion
- rem  output  WIDTH  remainder, registered, held until next completion
- dbz  output  1  divide-by-zero flag for the last completed operation, held

## Operation
- Internal registers:
  - R: partial remainder, WIDTH+1 bits. The extra bit is mandatory, because after a shift R can reach 2·B−1.
  - Q: dividend/quotient shift register, WIDTH bits.
  - D: divisor, WIDTH bits.
  - cnt: iteration counter, $clog2(WIDTH+1) bits.
- States: IDLE, SHIFT, SUB, DONE.
- IDLE, start=1, B≠0:
  - R←0, Q←A, D←B, cnt←WIDTH.
  - → SHIFT.
- IDLE, start=1, B=0:
  - quot←all ones, rem←A, dbz←1.
  - → DONE.
- IDLE, start=0: hold everything.
- SHIFT:
  - {R,Q} ← {R,Q} << 1, with a zero shifted into Q[0].
  - → SUB.
- SUB:
  - If R ≥ {0,D}: R←R−D and Q[0]←1; else R and Q are unchanged.
  - cnt←cnt−1.
  - If cnt−1 = 0, load quot←Q (post-update) and rem←R[WIDTH-1:0] (post-update), set dbz←0, → DONE; else → SHIFT.
- DONE: done=1 for this cycle only; → IDLE unconditionally.
- Arithmetic is unsigned throughout. The final remainder is always < D, so R[WIDTH] = 0 at completion.

## Timing
- Reset (synchronous, takes effect at the edge where reset=1):
  - State, R, Q, D, cnt, quot, rem, dbz, done, busy all go to 0; state=IDLE.
  - Reset dominates start.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Latency, counting the edge that samples start=1 in IDLE as edge 1:
  - Normal divide: state is DONE after edge 2·WIDTH+1, so done is high in the following cycle (after 17 edges for WIDTH=8). IDLE returns at edge 2·WIDTH+2.
  - B=0: done is high in the cycle after edge 1.
- Output timing:
  - quot/rem/dbz change only on the edge that enters DONE, and are therefore valid while done=1.
  - Otherwise they hold their last values.
- busy is high from the cycle after the accepting edge through the DONE cycle inclusive.
- Input rules:
  - start is ignored in SHIFT, SUB and DONE; a start held high during DONE is not accepted.
  - start is accepted on the first edge in IDLE, so the back-to-back issue interval is 2·WIDTH+2 cycles.
  - A and B are don't-care after the accepting edge.
- Pulse width: done is never high for two consecutive cycles.

## Test plan
- Basic divide: reset, then A=200, B=7, start for 1 cycle → done exactly 17 edges later; quot=28, rem=4, dbz=0; busy high for 17 cycles.
- Edge operands:
  - A=255, B=1 → quot=255, rem=0.
  - A=5, B=9 → quot=0, rem=5.
  - A=0, B=3 → quot=0, rem=0.
  - A=255, B=255 → quot=1, rem=0.
- Divide by zero: A=17, B=0 → done in the cycle after the start edge; quot=255, rem=17, dbz=1. Then A=9, B=3 → quot=3, rem=0, dbz=0.
- Handshake:
  - start held high continuously with changing A/B → each operation uses the operands present on its accepting edge.
  - Operations run back to back every 18 cycles.
  - Pulsing start mid-operation has no effect.
- Reset mid-operation: assert reset at edge 6 of A=100, B=3 → all outputs 0 on the next cycle and no done pulse. A new start then completes correctly: A=100, B=3 → quot=33, rem=1.
- Exhaustive check with WIDTH=8: all 65536 (A, B) pairs compared against A/B and A%B (B=0 uses the dbz rule). Also assert R[WIDTH]=0 at DONE and that done is never high for two consecutive cycles.

Source files
------------

// File: rtl/seqdiv.sv
// Sequential restoring shift-subtract divider with a start/done handshake.
// Divide-by-zero completes in one step with quot all ones and rem = A.
module seqdiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SUB   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_diff;
    logic             r_ge;
    logic [CW-1:0]    cnt_dec;

    // R carries one extra bit because a shifted R can reach 2*D-1.
    assign r_diff  = r_q - {1'b0, d_q};
    assign r_ge    = r_q >= {1'b0, d_q};
    assign cnt_dec = cnt_q - 1'b1;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        quot_d  = '1;
                        rem_d   = A;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = A;
                        d_d     = B;
                        cnt_d   = CW'(WIDTH);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
                state_d    = SUB;
            end
            SUB: begin
                if (r_ge) begin
                    r_d = r_diff;
                    q_d = {q_q[WIDTH-1:1], 1'b1};
                end
                cnt_d = cnt_dec;
                if (cnt_dec == '0) begin
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign quot = quot_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_seqdiv.sv
// Bench for seqdiv: directed operations checked against hand values and
// against a cycle-level arithmetic model compared on every falling edge.
module tb_seqdiv;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dbz;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit prev_done = 0;

    // Model: cycles left in the busy window; done is its last cycle.
    int           m_left = 0;
    logic [W-1:0] m_pq, m_pr, m_q, m_r;
    logic         m_pz, m_z;

    seqdiv #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .quot (quot),
        .rem  (rem),
        .dbz  (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_q = '0;
            m_r = '0;
            m_z = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                if (B == 0) begin
                    m_pq = '1;
                    m_pr = A;
                    m_pz = 1'b1;
                    m_left = 1;
                end else begin
                    m_pq = A / B;
                    m_pr = A % B;
                    m_pz = 1'b0;
                    m_left = 2 * W + 1;
                end
            end
        end else begin
            m_left--;
        end
        if (!reset && m_left == 1) begin
            m_q = m_pq;
            m_r = m_pr;
            m_z = m_pz;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(m_left != 0));
            chk("done", int'(done), int'(m_left == 1));
            chk("quot", int'(quot), int'(m_q));
            chk("rem", int'(rem), int'(m_r));
            chk("dbz", int'(dbz), int'(m_z));
            if (done) begin
                chk("done_twice", int'(prev_done), 0);
                chk("r_top_zero", int'(dut.r_q[W]), 0);
            end
        end
        prev_done = done;
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int lat, input bit glitch);
        int n;
        A = a;
        B = b;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                A = W'($urandom);
                B = W'($urandom);
            end
            if (glitch && n == 5) start = 1'b1;
            if (glitch && n == 7) start = 1'b0;
        end while (!done && n < 40);
        chk("latency", n, lat);
        chk("op_quot", int'(quot), int'(eq));
        chk("op_rem", int'(rem), int'(er));
        chk("op_dbz", int'(dbz), int'(ez));
        start = 1'b0;
        @(negedge clk);
    endtask

    logic [W-1:0] al[8] = '{0, 1, 2, 127, 128, 200, 254, 255};
    logic [W-1:0] bl[8] = '{0, 1, 2, 3, 7, 16, 128, 255};
    logic [W-1:0] ba[4] = '{50, 255, 77, 13};
    logic [W-1:0] bb[4] = '{6, 16, 77, 200};
    logic [W-1:0] bq[4] = '{8, 15, 1, 0};
    logic [W-1:0] br[4] = '{2, 15, 0, 13};

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_dbz", int'(dbz), 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(200, 7, 28, 4, 0, 17, 0);
        do_op(255, 1, 255, 0, 0, 17, 0);
        do_op(5, 9, 0, 5, 0, 17, 0);
        do_op(0, 3, 0, 0, 0, 17, 0);
        do_op(255, 255, 1, 0, 0, 17, 0);
        do_op(17, 0, 255, 17, 1, 1, 0);
        do_op(9, 3, 3, 0, 0, 17, 0);
        do_op(200, 7, 28, 4, 0, 17, 1);

        // start held high with operands changed once per operation
        A = ba[0];
        B = bb[0];
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            chk("b2b_interval", n, (i == 0) ? 17 : 18);
            chk("b2b_quot", int'(quot), int'(bq[i]));
            chk("b2b_rem", int'(rem), int'(br[i]));
            if (i < 3) begin
                A = ba[i+1];
                B = bb[i+1];
            end
        end
        start = 1'b0;
        @(negedge clk);

        // reset lands on edge 6 of an operation
        A = 100;
        B = 3;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quot", int'(quot), 0);
        chk("abort_rem", int'(rem), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        do_op(100, 3, 33, 1, 0, 17, 0);

        foreach (al[i]) begin
            foreach (bl[j]) begin
                do_op(al[i], bl[j],
                      (bl[j] == 0) ? 8'hFF : al[i] / bl[j],
                      (bl[j] == 0) ? al[i] : al[i] % bl[j],
                      bl[j] == 0, (bl[j] == 0) ? 1 : 17, 0);
            end
        end

        for (int k = 0; k < 150; k++) begin
            ra = W'($urandom);
            rb = (k % 16 == 0) ? 8'd0 : W'($urandom);
            do_op(ra, rb,
                  (rb == 0) ? 8'hFF : ra / rb,
                  (rb == 0) ? ra : ra % rb,
                  rb == 0, (rb == 0) ? 1 : 17, k % 5 == 0 && rb != 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
